// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant, held for a whole packet.
// The master datapath is a zero-latency mux of the granted slave port.
module axis_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 1,
    parameter int DATA_COUNT = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             port_en,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    output logic [NUM_PORTS-1:0]             s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*DATA_COUNT-1:0]  s_tkeep,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [DATA_COUNT-1:0]            m_tkeep,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             m_tlast,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             busy,
    output logic [31:0]                      pkt_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_PORTS - 1);

    state_t                 state;
    logic [ID_WIDTH-1:0]    rr_ptr;
    logic [NUM_PORTS-1:0]   req;
    logic [ID_WIDTH-1:0]    pick;
    logic                   pick_vld;
    logic                   eop;

    function automatic logic [ID_WIDTH-1:0] wrap_add(logic [ID_WIDTH-1:0] base, int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return ID_WIDTH'(s);
    endfunction

    assign req = s_tvalid & port_en;

    // First requester at or after rr_ptr, wrapping around the port list.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!pick_vld && req[wrap_add(rr_ptr, k)]) begin
                pick     = wrap_add(rr_ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        m_tdata  = s_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep  = s_tkeep[grant_id*DATA_COUNT +: DATA_COUNT];
        m_tuser  = s_tuser[grant_id*USER_WIDTH +: USER_WIDTH];
        m_tlast  = s_tlast[grant_id];
        m_tvalid = (state == BUSY) && s_tvalid[grant_id];
        s_tready = '0;
        if (state == BUSY) s_tready[grant_id] = m_tready;
    end

    assign eop = m_tvalid && m_tready && m_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // The grant is only released by the last beat of the packet.
                    if (eop) begin
                        rr_ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        pkt_cnt <= pkt_cnt + 32'd1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
